// File: rtl/score_hex_display.sv
// Binary-to-BCD score display driver: sequential shift-add-3 conversion, saturation, blink, blank.
// Optional leading-zero blanking enabled by defining SCORE_HEX_DISPLAY_LZB_EN.
module score_hex_display #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic [VALUE_W-1:0]        value,
    input  logic                      load,
    input  logic                      blink_en,
    input  logic                      blank,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [7*NUM_DIGITS-1:0]   hex_out
);

    localparam int BcdW   = 4 * NUM_DIGITS;
    localparam int CntW   = $clog2(VALUE_W + 1);
    localparam int BlinkW = $clog2(BLINK_DIV);
    localparam logic [VALUE_W-1:0] MaxVal = VALUE_W'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

    state_e                 state_q, state_d;
    logic [VALUE_W-1:0]     bin_q, bin_d;
    logic [BcdW-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [CntW-1:0]        iter_q, iter_d;
    logic                   ovf_next_q, ovf_next_d;
    logic [BcdW-1:0]        disp_q, disp_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [BlinkW-1:0]      blink_cnt_q, blink_cnt_d;
    logic                   blink_off_q, blink_off_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]  digit_on;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        ovf_next_d = ovf_next_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    bin_d      = value;
                    bcd_d      = '0;
                    iter_d     = CntW'(VALUE_W);
                    ovf_next_d = (value > MaxVal);
                    state_d    = StConv;
                end
            end
            StConv: begin
                // Bits shifted out of the top BCD nibble are dropped; saturation covers that case.
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d = iter_q - CntW'(1);
                if (iter_q == CntW'(1)) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                disp_d  = ovf_next_q ? {NUM_DIGITS{4'd9}} : bcd_q;
                ovf_d   = ovf_next_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end
    end

`ifdef SCORE_HEX_DISPLAY_LZB_EN
    always_comb begin : lzb
        logic seen;
        seen     = 1'b0;
        digit_on = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (disp_q[4*i +: 4] != 4'd0) | (i == 0);
            digit_on[i] = seen;
        end
    end
`else
    assign digit_on = '1;
`endif

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            // blink_en gating makes dropping blink visible on the very next cycle.
            if (!blank && !(blink_en && blink_off_q) && digit_on[i]) begin
                hex_d[7*i +: 7] = seg7(disp_q[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            ovf_next_q  <= 1'b0;
            disp_q      <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            hex_q       <= '1;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            ovf_next_q  <= ovf_next_d;
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            hex_q       <= hex_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign hex_out  = hex_q;

endmodule
